// File: rtl/imm_gen_pipe_if.sv
// Handshake bundle for imm_gen_pipe: input offer, output entry, flush.
// slave = the stage itself, master = producer/consumer side driving it.
interface imm_gen_pipe_if #(
  parameter int XLEN = 32
);
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_inst;
  logic [2:0]      in_imm_type;
  logic [XLEN-1:0] in_pc;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_imm;
  logic [XLEN-1:0] out_target;
  logic            out_illegal;

  modport master (
    output flush, in_valid, in_inst,
    output in_imm_type, in_pc, out_ready,
    input  in_ready, out_valid, out_imm,
    input  out_target, out_illegal
  );

  modport slave (
    input  flush, in_valid, in_inst,
    input  in_imm_type, in_pc, out_ready,
    output in_ready, out_valid, out_imm,
    output out_target, out_illegal
  );
endinterface

// File: rtl/imm_gen_pipe.sv
// Registered immediate generator with output reg + 1 skid entry.
// Ports: clk, reset (sync, active high), bus (imm_gen_pipe_if.slave).
module imm_gen_pipe #(
  parameter int XLEN        = 32,
  parameter bit ENABLE_ZIMM = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  imm_gen_pipe_if.slave bus
);

  typedef struct packed {
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] target;
    logic            illegal;
    logic            valid;
  } ent_t;

  ent_t            or_q;
  ent_t            sk_q;
  ent_t            in_e;
  logic [31:0]     i;
  logic [XLEN-1:0] imm;
  logic            illegal;
  logic            in_xfer;
  logic            or_free;
  logic            unused;

  assign i      = bus.in_inst;
  assign unused = ^i[6:0];

  // Sign extension comes from the size cast of a signed operand.
  always_comb begin
    imm     = '0;
    illegal = 1'b0;
    unique case (bus.in_imm_type)
      3'd0: imm = '0;
      3'd1: imm = XLEN'($signed(i[31:20]));
      3'd2: imm = (XLEN == 64) ? XLEN'(i[25:20])
                               : XLEN'(i[24:20]);
      3'd3: imm = XLEN'($signed({i[31:25], i[11:7]}));
      3'd4: imm = XLEN'($signed({i[31], i[7],
                    i[30:25], i[11:8], 1'b0}));
      3'd5: imm = XLEN'($signed({i[31:12], 12'b0}));
      3'd6: imm = XLEN'($signed({i[31], i[19:12],
                    i[20], i[30:21], 1'b0}));
      3'd7: begin
        if (ENABLE_ZIMM) imm = XLEN'(i[19:15]);
        else illegal = 1'b1;
      end
    endcase
  end

  always_comb begin
    in_e         = '0;
    in_e.imm     = imm;
    in_e.target  = bus.in_pc + imm;
    in_e.illegal = illegal;
    in_e.valid   = 1'b1;
  end

  // in_ready depends only on the skid flag, never on out_ready.
  assign bus.in_ready = !sk_q.valid;
  assign in_xfer      = bus.in_valid && !sk_q.valid;
  assign or_free      = !or_q.valid || bus.out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      or_q <= '0;
      sk_q <= '0;
    end else if (bus.flush) begin
      or_q.valid <= 1'b0;
      sk_q.valid <= 1'b0;
    end else if (or_free) begin
      if (sk_q.valid) begin
        or_q <= sk_q;
        if (in_xfer) sk_q <= in_e;
        else sk_q.valid <= 1'b0;
      end else if (in_xfer) begin
        or_q <= in_e;
      end else begin
        or_q.valid <= 1'b0;
      end
    end else if (in_xfer) begin
      sk_q <= in_e;
    end
  end

  assign bus.out_valid   = or_q.valid;
  assign bus.out_imm     = or_q.imm;
  assign bus.out_target  = or_q.target;
  assign bus.out_illegal = or_q.illegal;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Scoreboard bench for imm_gen_pipe: three configs share one stimulus.
// Instances: XLEN32/ZIMM1, XLEN32/ZIMM0, XLEN64/ZIMM1.
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic [31:0] inst;
  logic [2:0]  ty;
  logic [63:0] pc;
  logic        out_ready;

  int checks   = 0;
  int failures = 0;
  bit mon_en   = 1'b0;

  always #5 clk = ~clk;

  imm_gen_pipe_if #(.XLEN(32)) b32 ();
  imm_gen_pipe_if #(.XLEN(32)) bz ();
  imm_gen_pipe_if #(.XLEN(64)) b64 ();

  assign b32.flush = flush;       assign bz.flush = flush;
  assign b64.flush = flush;
  assign b32.in_valid = in_valid; assign bz.in_valid = in_valid;
  assign b64.in_valid = in_valid;
  assign b32.in_inst = inst;      assign bz.in_inst = inst;
  assign b64.in_inst = inst;
  assign b32.in_imm_type = ty;    assign bz.in_imm_type = ty;
  assign b64.in_imm_type = ty;
  assign b32.in_pc = pc[31:0];    assign bz.in_pc = pc[31:0];
  assign b64.in_pc = pc;
  assign b32.out_ready = out_ready;
  assign bz.out_ready = out_ready;
  assign b64.out_ready = out_ready;

  imm_gen_pipe #(.XLEN(32), .ENABLE_ZIMM(1'b1)) u32 (
    .clk(clk), .reset(reset), .bus(b32.slave));
  imm_gen_pipe #(.XLEN(32), .ENABLE_ZIMM(1'b0)) uz (
    .clk(clk), .reset(reset), .bus(bz.slave));
  imm_gen_pipe #(.XLEN(64), .ENABLE_ZIMM(1'b1)) u64 (
    .clk(clk), .reset(reset), .bus(b64.slave));

  logic        ov[3];
  logic        ir[3];
  logic        ol[3];
  logic [63:0] oi[3];
  logic [63:0] ot[3];

  assign ov[0] = b32.out_valid;   assign ov[1] = bz.out_valid;
  assign ov[2] = b64.out_valid;
  assign ir[0] = b32.in_ready;    assign ir[1] = bz.in_ready;
  assign ir[2] = b64.in_ready;
  assign ol[0] = b32.out_illegal; assign ol[1] = bz.out_illegal;
  assign ol[2] = b64.out_illegal;
  assign oi[0] = 64'(b32.out_imm); assign oi[1] = 64'(bz.out_imm);
  assign oi[2] = b64.out_imm;
  assign ot[0] = 64'(b32.out_target);
  assign ot[1] = 64'(bz.out_target);
  assign ot[2] = b64.out_target;

  typedef struct {
    logic [63:0] imm;
    logic [63:0] tgt;
    logic        ill;
  } exp_t;

  exp_t q[3][$];
  bit   acc[3];
  int   xl[3] = '{32, 32, 64};
  bit   zm[3] = '{1'b1, 1'b0, 1'b1};

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic longint sx(input longint x, input int n);
    if (x >= (longint'(1) << (n - 1))) return x - (longint'(1) << n);
    return x;
  endfunction

  function automatic logic [63:0] fit(input longint v, input int w);
    if (w == 64) return v;
    return v & 64'hFFFF_FFFF;
  endfunction

  // Reference immediate from the field layout, as plain arithmetic.
  function automatic exp_t model(input int k, input logic [31:0] in,
                                 input logic [2:0] t,
                                 input logic [63:0] p);
    longint u = longint'(in);
    longint v = 0;
    exp_t   e;
    e.ill = 1'b0;
    case (t)
      3'd1: v = sx((u >> 20) & 'hFFF, 12);
      3'd2: v = (xl[k] == 64) ? (u >> 20) & 63 : (u >> 20) & 31;
      3'd3: v = sx(((u >> 25) << 5) + ((u >> 7) & 31), 12);
      3'd4: v = sx(((u >> 31) & 1) * 4096 + ((u >> 7) & 1) * 2048
                 + ((u >> 25) & 63) * 32 + ((u >> 8) & 15) * 2, 13);
      3'd5: v = sx(u & 'hFFFF_F000, 32);
      3'd6: v = sx(((u >> 31) & 1) * (1 << 20)
                 + ((u >> 12) & 255) * 4096
                 + ((u >> 20) & 1) * 2048
                 + ((u >> 21) & 1023) * 2, 21);
      3'd7: begin
        if (zm[k]) v = (u >> 15) & 31;
        else e.ill = 1'b1;
      end
      default: v = 0;
    endcase
    e.imm = fit(v, xl[k]);
    e.tgt = fit(longint'(p) + longint'(e.imm), xl[k]);
    return e;
  endfunction

  // Monitor: check handshake flags and pop on output transfer.
  initial forever begin
    @(negedge clk);
    if (mon_en) begin
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("in_ready[%0d]", k), 64'(ir[k]),
            64'(q[k].size() < 2));
        chk($sformatf("out_valid[%0d]", k), 64'(ov[k]),
            64'(q[k].size() > 0));
        acc[k] = q[k].size() < 2;
        if (ov[k] && q[k].size() > 0) begin
          chk($sformatf("imm[%0d]", k), oi[k], q[k][0].imm);
          chk($sformatf("target[%0d]", k), ot[k], q[k][0].tgt);
          chk($sformatf("illegal[%0d]", k), 64'(ol[k]),
              64'(q[k][0].ill));
          if (out_ready) void'(q[k].pop_front());
        end
        if (reset || flush) q[k].delete();
      end
    end
  end

  // Stimulus side: push the expected entry for every accepted offer.
  initial forever begin
    @(negedge clk);
    #1;
    if (mon_en && in_valid && !flush && !reset)
      for (int k = 0; k < 3; k++)
        if (acc[k]) q[k].push_back(model(k, inst, ty, pc));
  end

  task automatic send(input logic [31:0] i_, input logic [2:0] t_,
                      input logic [63:0] p_);
    bit ok = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b1; inst = i_; ty = t_; pc = p_;
    for (int n = 0; n < 50 && !ok; n++) begin
      @(negedge clk);
      if (ir[0]) ok = 1'b1;
      else begin
        @(posedge clk);
        #1;
      end
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL send_timeout actual=0 required=1");
    end
  endtask

  task automatic idle(input int n);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    flush    = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string nm);
    for (int k = 0; k < 3; k++) begin
      chk({nm, "_valid"}, 64'(ov[k]), 64'd0);
      chk({nm, "_ready"}, 64'(ir[k]), 64'd1);
      chk({nm, "_imm"}, oi[k], 64'd0);
      chk({nm, "_target"}, ot[k], 64'd0);
      chk({nm, "_illegal"}, 64'(ol[k]), 64'd0);
    end
  endtask

  // Known answers: one offer, checked one cycle later.
  task automatic kat(input string nm, input logic [31:0] i_,
                     input logic [2:0] t_, input logic [63:0] e32,
                     input logic [63:0] g32, input logic [63:0] ez,
                     input logic iz, input logic [63:0] e64);
    @(posedge clk);
    #1;
    in_valid = 1'b1; inst = i_; ty = t_; pc = 64'h100;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk({nm, "_v"}, 64'(ov[0]), 64'd1);
    chk({nm, "_imm32"}, oi[0], e32);
    chk({nm, "_tgt32"}, ot[0], g32);
    chk({nm, "_immz"}, oi[1], ez);
    chk({nm, "_illz"}, 64'(ol[1]), 64'(iz));
    chk({nm, "_imm64"}, oi[2], e64);
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0;
    inst = '0; ty = '0; pc = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset  = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);
    chk_zero("reset");

    kat("i", 32'hFFF00093, 3'd1, 64'hFFFF_FFFF, 64'hFF,
        64'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF);
    kat("b", 32'hFE000EE3, 3'd4, 64'hFFFF_FFFC, 64'hFC,
        64'hFFFF_FFFC, 1'b0, 64'hFFFF_FFFF_FFFF_FFFC);
    kat("u", 32'h123450B7, 3'd5, 64'h1234_5000, 64'h1234_5100,
        64'h1234_5000, 1'b0, 64'h1234_5000);
    kat("ish", 32'h01F09093, 3'd2, 64'h1F, 64'h11F,
        64'h1F, 1'b0, 64'h1F);
    kat("ish64", 32'h03F00093, 3'd2, 64'h1F, 64'h11F,
        64'h1F, 1'b0, 64'd63);
    kat("z", 32'h000F8073, 3'd7, 64'h1F, 64'h11F,
        64'h0, 1'b1, 64'h1F);

    // Backpressure: A to OR, B to SK, C held until SK drains.
    idle(2);
    out_ready = 1'b0;
    send(32'hFFF00093, 3'd1, 64'h200);
    send(32'h123450B7, 3'd5, 64'h300);
    fork
      send(32'hFE000EE3, 3'd4, 64'h400);
      begin
        repeat (4) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    idle(5);

    // Flush with both entries full and a new offer present.
    out_ready = 1'b0;
    send(32'h00500093, 3'd1, 64'h500);
    send(32'h00600093, 3'd1, 64'h600);
    @(posedge clk);
    #1;
    in_valid = 1'b1; inst = 32'h00700093; ty = 3'd1; flush = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    send(32'h00800093, 3'd1, 64'h800);
    idle(5);

    for (int n = 0; n < 3000; n++) begin
      @(posedge clk);
      #1;
      in_valid  = ($urandom % 4) != 0;
      inst      = $urandom;
      ty        = 3'($urandom % 8);
      pc        = {$urandom, $urandom};
      out_ready = ($urandom % 3) != 0;
      flush     = ($urandom % 40) == 0;
    end
    out_ready = 1'b1;
    idle(5);
    @(negedge clk);
    for (int k = 0; k < 3; k++)
      chk($sformatf("drained[%0d]", k), 64'(q[k].size()), 64'd0);

    // Reset in the middle of a stall clears everything.
    out_ready = 1'b0;
    send(32'hFFF00093, 3'd1, 64'h900);
    send(32'hFE000EE3, 3'd4, 64'hA00);
    @(posedge clk);
    #1;
    reset = 1'b1; in_valid = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk_zero("midreset");
    idle(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
